// File: rtl/bnn_seq_core.sv
// rtl/bnn_seq_core.sv - time-multiplexed two-layer XNOR-popcount binary network
// Optional argmax tracking of the output layer is enabled by defining BNN_ARGMAX_EN.
module bnn_seq_core #(
  parameter int N_IN  = 8,
  parameter int N_HID = 12,
  parameter int N_OUT = 8,
  parameter int TW    = 4,
  localparam int CW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             setup,
  input  logic             param_in,
  output logic             param_out,
  input  logic [N_IN-1:0]  x_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] y_out,
  output logic [CW-1:0]    class_idx
);

  localparam int HR     = N_IN + TW;
  localparam int OR     = N_HID + TW;
  localparam int L      = N_HID * HR + N_OUT * OR;
  localparam int OBASE  = N_HID * HR;
  localparam int MAXN   = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int IW     = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int XW     = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int SW0    = $clog2(XW + 1);
  localparam int SW     = (SW0 > TW) ? SW0 : TW;
  localparam int OSW    = $clog2(N_HID + 1);

  typedef enum logic [1:0] {IDLE, HID, OUT} state_t;

  state_t           state;
  logic [L-1:0]     p;
  logic [N_IN-1:0]  xr;
  logic [N_HID-1:0] hid;
  logic [N_OUT-1:0] ybuf;
  logic [IW-1:0]    idx;

  logic [XW-1:0]    act;
  logic [XW-1:0]    wts;
  logic [TW-1:0]    thr;
  int               n_act;
  logic [SW-1:0]    score;
  logic             fire;
  logic [N_OUT-1:0] ybuf_n;

  assign param_out = p[0];

  // Shared neuron datapath: the record is selected by layer (state) and idx.
  always_comb begin
    act   = '0;
    wts   = '0;
    thr   = '0;
    n_act = N_IN;
    if (state == OUT) begin
      act[N_HID-1:0] = hid;
      wts[N_HID-1:0] = p[OBASE + int'(idx) * OR +: N_HID];
      thr            = p[OBASE + int'(idx) * OR + N_HID +: TW];
      n_act          = N_HID;
    end else begin
      act[N_IN-1:0] = xr;
      wts[N_IN-1:0] = p[int'(idx) * HR +: N_IN];
      thr           = p[int'(idx) * HR + N_IN +: TW];
    end
    score = '0;
    for (int i = 0; i < XW; i++) begin
      if (i < n_act && act[i] == wts[i]) score = score + SW'(1);
    end
    fire        = (score >= SW'(thr));
    ybuf_n      = ybuf;
    ybuf_n[idx] = fire;
  end

`ifdef BNN_ARGMAX_EN
  logic [OSW-1:0] best_sc;
  logic [CW-1:0]  best_ix;
  logic [CW-1:0]  cls_q;
  logic           take;
  logic [OSW-1:0] best_sc_n;
  logic [CW-1:0]  best_ix_n;

  // Strictly-greater replacement keeps the lowest index on ties.
  assign take      = (idx == '0) || (score > SW'(best_sc));
  assign best_sc_n = take ? score[OSW-1:0] : best_sc;
  assign best_ix_n = take ? idx[CW-1:0] : best_ix;
  assign class_idx = cls_q;
`else
  assign class_idx = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= '0;
      xr    <= '0;
      hid   <= '0;
      ybuf  <= '0;
      idx   <= '0;
      y_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BNN_ARGMAX_EN
      best_sc <= '0;
      best_ix <= '0;
      cls_q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (setup) begin
        p     <= {param_in, p[L-1:1]};
        state <= IDLE;
        busy  <= 1'b0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              xr    <= x_in;
              idx   <= '0;
              state <= HID;
              busy  <= 1'b1;
            end
          end
          HID: begin
            hid[idx] <= fire;
            if (idx == IW'(N_HID - 1)) begin
              idx   <= '0;
              state <= OUT;
            end else begin
              idx <= idx + IW'(1);
            end
          end
          OUT: begin
            ybuf <= ybuf_n;
`ifdef BNN_ARGMAX_EN
            best_sc <= best_sc_n;
            best_ix <= best_ix_n;
`endif
            if (idx == IW'(N_OUT - 1)) begin
              y_out <= ybuf_n;
              done  <= 1'b1;
              busy  <= 1'b0;
              idx   <= '0;
              state <= IDLE;
`ifdef BNN_ARGMAX_EN
              cls_q <= best_ix_n;
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bnn_seq_core.sv
// tb/tb_bnn_seq_core.sv - directed table-driven bench for bnn_seq_core at default parameters
module tb_bnn_seq_core;

  localparam int L = 272;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       setup = 1'b0;
  logic       param_in = 1'b0;
  logic       param_out;
  logic [7:0] x_in = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] y_out;
  logic [2:0] class_idx;

  int total = 0;
  int bad = 0;

  logic [7:0]  hw [12];
  logic [3:0]  ht [12];
  logic [11:0] ow [8];
  logic [3:0]  ot [8];

  typedef struct {
    int         cfg;
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  vec_t tbl [14];

  bnn_seq_core dut (
    .clk(clk), .rst_n(rst_n), .setup(setup), .param_in(param_in),
    .param_out(param_out), .x_in(x_in), .start(start), .busy(busy),
    .done(done), .y_out(y_out), .class_idx(class_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] w_h, input logic [3:0] t_h,
                      input logic [11:0] w_o, input logic [3:0] t_o);
    for (int i = 0; i < 12; i++) begin hw[i] = w_h; ht[i] = t_h; end
    for (int i = 0; i < 8; i++) begin ow[i] = w_o; ot[i] = t_o; end
  endtask

  task automatic load();
    logic [L-1:0] pv;
    pv = '0;
    for (int h = 0; h < 12; h++) begin
      pv[h*12 +: 8]    = hw[h];
      pv[h*12+8 +: 4]  = ht[h];
    end
    for (int o = 0; o < 8; o++) begin
      pv[144+o*16 +: 12]    = ow[o];
      pv[144+o*16+12 +: 4]  = ot[o];
    end
    for (int i = 0; i < L; i++) begin
      setup = 1'b1;
      param_in = pv[i];
      tick();
    end
    setup = 1'b0;
    param_in = 1'b0;
  endtask

  task automatic set_cfg(input int c);
    case (c)
      1: fill(8'hFF, 4'd8, 12'hFFF, 4'd12);
      2: fill(8'h00, 4'd4, 12'hFFF, 4'd12);
      3: fill(8'h00, 4'd0, 12'h000, 4'd15);
      4: fill(8'h0F, 4'd8, 12'hFFF, 4'd12);
      default: fill(8'h00, 4'd0, 12'h000, 4'd0);
    endcase
    load();
  endtask

  task automatic run_inf(input logic [7:0] x, output logic [7:0] y,
                         output logic [2:0] c, output int nd);
    x_in = x;
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    y = 'x;
    c = 'x;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) begin
        nd++;
        y = y_out;
        c = class_idx;
      end
    end
  endtask

  initial begin
    logic [7:0]   y;
    logic [2:0]   c;
    logic [L-1:0] pat;
    logic [15:0]  lfsr;
    int           nd;
    int           cur;
    logic [2:0]   exp_c;

    tbl[0]  = '{0, 8'h00, 8'hFF};
    tbl[1]  = '{0, 8'h3C, 8'hFF};
    tbl[2]  = '{1, 8'hFF, 8'hFF};
    tbl[3]  = '{1, 8'hFE, 8'h00};
    tbl[4]  = '{1, 8'h7F, 8'h00};
    tbl[5]  = '{1, 8'h00, 8'h00};
    tbl[6]  = '{1, 8'hFF, 8'hFF};
    tbl[7]  = '{2, 8'h0F, 8'hFF};
    tbl[8]  = '{2, 8'h1F, 8'h00};
    tbl[9]  = '{2, 8'h00, 8'hFF};
    tbl[10] = '{3, 8'h00, 8'h00};
    tbl[11] = '{4, 8'h0F, 8'hFF};
    tbl[12] = '{4, 8'hF0, 8'h00};
    tbl[13] = '{4, 8'h1F, 8'h00};

    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_y", y_out, 0);
    chk("reset_cls", class_idx, 0);
    chk("reset_pout", param_out, 0);
    rst_n = 1'b1;
    tick();

    // Latency: start accepted on edge 1, done visible after edge 21.
    x_in = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_busy_e1", busy, 1);
    for (int k = 2; k <= 20; k++) begin
      tick();
      chk($sformatf("lat_busy_e%0d", k), busy, 1);
      chk($sformatf("lat_nodone_e%0d", k), done, 0);
    end
    tick();
    chk("lat_done_e21", done, 1);
    chk("lat_busy_e21", busy, 0);
    chk("lat_y", y_out, 8'hFF);
    chk("lat_cls", class_idx, 0);
    tick();
    chk("lat_done_e22", done, 0);
    chk("lat_y_hold", y_out, 8'hFF);

    cur = -1;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].cfg != cur) begin
        set_cfg(tbl[i].cfg);
        cur = tbl[i].cfg;
      end
      run_inf(tbl[i].x, y, c, nd);
      chk($sformatf("vec%0d_ndone", i), nd, 1);
      chk($sformatf("vec%0d_y", i), y, tbl[i].y);
      chk($sformatf("vec%0d_cls", i), c, 0);
    end

    // Chain integrity: pattern emerges at param_out after L shifts.
    lfsr = 16'hACE1;
    for (int i = 0; i < L; i++) begin
      pat[i] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    for (int k = 1; k <= 2 * L; k++) begin
      setup = 1'b1;
      param_in = (k <= L) ? pat[k-1] : 1'b0;
      tick();
      if (k >= L && k < 2 * L) chk($sformatf("chain_bit%0d", k - L), param_out, pat[k-L]);
    end
    setup = 1'b0;

    // Start is ignored while setup is high.
    start = 1'b1;
    setup = 1'b1;
    tick();
    start = 1'b0;
    setup = 1'b0;
    chk("setup_blocks_start", busy, 0);

    // Setup mid-inference aborts with no done and unchanged y_out.
    set_cfg(1);
    run_inf(8'hFF, y, c, nd);
    chk("abort_pre_y", y, 8'hFF);
    x_in = 8'hFE;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort_busy_before", busy, 1);
    setup = 1'b1;
    tick();
    setup = 1'b0;
    chk("abort_busy", busy, 0);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) nd++;
    end
    chk("abort_ndone", nd, 0);
    chk("abort_y_hold", y_out, 8'hFF);

    // Start while busy is ignored; exactly one done follows.
    set_cfg(1);
    x_in = 8'hFE;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    x_in = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) nd++;
    end
    chk("busy_start_ndone", nd, 1);
    chk("busy_start_y", y_out, 8'h00);
    chk("busy_start_idle", busy, 0);

    // Asynchronous reset mid-inference.
    run_inf(8'hFF, y, c, nd);
    chk("pre_rst_y", y, 8'hFF);
    x_in = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_y", y_out, 0);
    chk("arst_pout", param_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_inf(8'h5A, y, c, nd);
    chk("post_rst_ndone", nd, 1);
    chk("post_rst_y", y, 8'hFF);

    // Argmax: hidden layer all fires, output score = popcount(weights).
    fill(8'h00, 4'd0, 12'h0FF, 4'd0);
    ow[2] = 12'hFFF;
    ow[5] = 12'hFFF;
    load();
    run_inf(8'h33, y, c, nd);
    chk("amax_tie_y", y, 8'hFF);
`ifdef BNN_ARGMAX_EN
    exp_c = 3'd2;
`else
    exp_c = 3'd0;
`endif
    chk("amax_tie_cls", c, exp_c);
    ow[2] = 12'h7FF;
    load();
    run_inf(8'h33, y, c, nd);
`ifdef BNN_ARGMAX_EN
    exp_c = 3'd5;
`else
    exp_c = 3'd0;
`endif
    chk("amax_uniq_cls", c, exp_c);
    chk("amax_uniq_cls_hold", class_idx, exp_c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_seq_core.md
Name: bnn_seq_core

Overview:
- Parametrised, time-multiplexed successor to the fixed 8-12-8 binarized network.
- Two fully connected binary layers (N_IN -> N_HID -> N_OUT).
- Each neuron is an XNOR-popcount-threshold unit, evaluated one neuron per clock by a shared datapath; the design no longer replicates neurons per unit.
- Weights and thresholds load through the same serial setup shift chain (param_in/param_out). Inference is start/busy/done handshaked.

Parameters:
- N_IN, 8: primary input width.
- N_HID, 12: hidden neurons (>=1).
- N_OUT, 8: output neurons (>=1).
- TW, 4: threshold field width per neuron (unsigned).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- setup  in  1  parameter-load mode; chain shifts one bit per clk while high.
- param_in  in  1  serial parameter bit.
- param_out  out  1  bit shifted out of the chain end.
- x_in  in  N_IN  input vector, sampled on the accepted start.
- start  in  1  request one inference.
- busy  out  1  inference in progress.
- done  out  1  one-cycle pulse: y_out updated.
- y_out  out  N_OUT  registered output-layer result.
- class_idx  out  max(1,clog2(N_OUT))  argmax index (see Optional Feature).

Behaviour:
- Parameter store: flat register P[L-1:0].
  - HR = N_IN+TW; OR = N_HID+TW; L = N_HID*HR + N_OUT*OR (272 at defaults).
  - Hidden neuron h record: P[h*HR +: HR].
  - Output neuron o record: P[N_HID*HR + o*OR +: OR].
  - Record layout: low bits are weights (bit i pairs with input i); top TW bits are the threshold.
- Shift: while setup=1, each edge P <= {param_in, P[L-1:1]}. param_out = P[0] combinationally. The host sends P[0] first; after L shifts that bit sits at P[0]. P holds when setup=0.
- Neuron function: fire = popcount(~(in ^ w)) >= thr. Compare unsigned after zero-extending both operands to the wider width.
- FSM states: IDLE, HID, OUT.
  - IDLE: start=1 and setup=0 at an edge -> latch x_in into xr, clear idx, go to HID.
  - HID: each edge writes hid[idx] = neuron(xr, hidden record idx). At idx=N_HID-1, go to OUT with idx=0.
  - OUT: each edge writes ybuf[idx] = neuron(hid, output record idx). At idx=N_OUT-1, y_out <= final ybuf (including this bit), done <= 1, go to IDLE.
- Latency: done is high in the cycle after edge number N_HID+N_OUT+1, counting the start-accept edge as 1 (21 edges at defaults). done lasts exactly one cycle.
- busy = (state != IDLE), registered.
- y_out holds its value between inferences.
- start while busy: ignored; no queueing.
- start while setup=1: ignored.
- setup=1 while busy (setup has priority): next edge returns the FSM to IDLE, busy=0, no done, y_out unchanged. The chain shifts on the same edge.
- Simultaneous done and new start: start is accepted on the edge after the return to IDLE; not in the same cycle.
- Reset (asynchronous, any time, including mid-inference): P=0, xr=0, hid=0, ybuf=0, y_out=0, busy=0, done=0, class_idx=0, FSM=IDLE.
- All-zero parameters give thr=0, so every neuron fires: y_out = all ones.

Optional Feature:
- Macro BNN_ARGMAX_EN.
- Defined:
  - During OUT, track the maximum output-neuron popcount and its index. A strictly greater score replaces the current maximum, so ties keep the lowest index.
  - class_idx is updated together with y_out, at the done edge.
  - Adds one score register of width clog2(N_HID+1) and one index register.
- Undefined: class_idx is tied to 0 and no extra registers are built.

Test Plan:
- Reset, no load, start with x_in=8'hA5 -> busy=1 for 20 cycles, done pulses once at edge 21, y_out=8'hFF; class_idx=0 with BNN_ARGMAX_EN.
- Load all hidden records as w=8'hFF, thr=8 and all output records as w=12'hFFF, thr=12:
  - x_in=8'hFF -> y_out=8'hFF.
  - then x_in=8'hFE -> y_out=8'h00.
- Chain integrity: shift a 272-bit LFSR pattern, then 272 zeros -> param_out reproduces the pattern bit-exact, starting on the 273rd shift edge.
- Inference with x_in=8'hFF gives y_out=8'hFF. Start again, assert setup at busy cycle 5 -> busy=0 next cycle, no done, y_out stays 8'hFF. Assert start again mid-run -> ignored, one done only.
- Deassert rst_n asynchronously mid-inference -> busy, done, y_out read 0 before the next clk edge. Post-reset inference -> y_out=8'hFF.
- BNN_ARGMAX_EN: load output records so neurons 2 and 5 both score 12 and the rest score less -> class_idx=2; make neuron 5 unique max -> class_idx=5.
